lock_guard: RTL

LOCK_GUARD -- requirements
Module: lock_guard

---
 rtl/lock_guard_if.sv | 29 ++
 rtl/lock_guard.sv | 119 +++++++++++
 2 files changed

// File: rtl/lock_guard_if.sv
// Signal bundle for lock_guard: raw buttons and lock-all request in, lock state and pulses out.
interface lock_guard_if #(
    parameter int unsigned N = 4
) ();
    logic [N-1:0] a_lck;
    logic         lock_all;
    logic [N-1:0] lock;
    logic [N-1:0] tr_lck;
    logic [N-1:0] led_lck;
    logic         any_unlocked;

    modport master (
        output a_lck,
        output lock_all,
        input  lock,
        input  tr_lck,
        input  led_lck,
        input  any_unlocked
    );

    modport slave (
        input  a_lck,
        input  lock_all,
        output lock,
        output tr_lck,
        output led_lck,
        output any_unlocked
    );
endinterface

// File: rtl/lock_guard.sv
// Per-channel hold-to-toggle lock: synchronised, debounced buttons, global lock-all request and
// idle auto-relock of unlocked channels.
`ifndef C_MS
`define C_MS(ms) ((ms) * 50000)
`endif

module lock_guard #(
    parameter int unsigned N          = 4,
    parameter int unsigned HOLD_CMAX  = `C_MS(1000),
    parameter int unsigned DEB_CMAX   = `C_MS(5),
    parameter int unsigned AUTO_CMAX  = `C_MS(30000),
    parameter bit          RST_LOCKED = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    lock_guard_if.slave  bus
);
    localparam int unsigned DW = $clog2(DEB_CMAX + 1);
    localparam int unsigned HW = $clog2(HOLD_CMAX + 1);
    localparam int unsigned AW = (AUTO_CMAX > 0) ? $clog2(AUTO_CMAX + 1) : 1;

    localparam logic [DW-1:0] DebLast  = DW'(DEB_CMAX - 1);
    localparam logic [HW-1:0] HoldLast = HW'(HOLD_CMAX - 1);
    localparam logic [AW-1:0] IdleMax  = AW'(AUTO_CMAX);
    localparam logic [AW-1:0] IdleLast = AW'((AUTO_CMAX > 0) ? AUTO_CMAX - 1 : 0);

    logic [N-1:0]         sync1_q, sync2_q;
    logic [N-1:0]         deb_q, deb_d;
    logic [N-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [N-1:0][HW-1:0] hold_q, hold_d;
    logic [N-1:0][AW-1:0] idle_q, idle_d;
    logic [N-1:0]         fired_q, fired_d;
    logic [N-1:0]         lock_q, lock_d;
    logic [N-1:0]         tr_q;
    logic                 any_q;
    logic [N-1:0]         toggle, relock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_cnt_q <= '0;
            hold_q    <= '0;
            idle_q    <= '0;
            fired_q   <= '0;
            lock_q    <= {N{RST_LOCKED}};
            tr_q      <= '0;
            any_q     <= !RST_LOCKED;
        end else begin
            sync1_q   <= bus.a_lck;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            hold_q    <= hold_d;
            idle_q    <= idle_d;
            fired_q   <= fired_d;
            lock_q    <= lock_d;
            tr_q      <= lock_d ^ lock_q;
            any_q     <= ~&lock_d;
        end
    end

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        hold_d    = hold_q;
        idle_d    = idle_q;
        fired_d   = fired_q;
        lock_d    = lock_q;
        toggle    = '0;
        relock    = '0;
        for (int i = 0; i < N; i++) begin
            // Count consecutive cycles that disagree with the debounced level.
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end

            if (!deb_q[i]) begin
                hold_d[i] = '0;
            end else if (!fired_q[i]) begin
                hold_d[i] = hold_q[i] + 1'b1;
                toggle[i] = (hold_q[i] == HoldLast);
            end

            relock[i] = (AUTO_CMAX > 0) && !lock_q[i] && !deb_q[i] && (idle_q[i] == IdleLast);

            if (bus.lock_all) begin
                lock_d[i] = 1'b1;
            end else if (toggle[i]) begin
                lock_d[i] = ~lock_q[i];
            end else if (relock[i]) begin
                lock_d[i] = 1'b1;
            end

            // Fired latches until the button is released, so one press toggles at most once.
            if (!deb_q[i]) begin
                fired_d[i] = 1'b0;
            end else if (bus.lock_all || toggle[i]) begin
                fired_d[i] = 1'b1;
            end

            if (lock_q[i] || deb_q[i] || (lock_d[i] != lock_q[i])) begin
                idle_d[i] = '0;
            end else if (idle_q[i] != IdleMax) begin
                idle_d[i] = idle_q[i] + 1'b1;
            end
        end
    end

    assign bus.lock         = lock_q;
    assign bus.led_lck      = lock_q;
    assign bus.tr_lck       = tr_q;
    assign bus.any_unlocked = any_q;
endmodule
